// File: rtl/arm_pipe_pkg.sv
// arm_pipe_pkg: shared FSM encoding and default sizing for the pipeline stall controller
package arm_pipe_pkg;
  typedef enum logic [1:0] {ST_RUN, ST_MEM_WAIT, ST_ERROR} state_t;
  localparam int DEF_MEM_TIMEOUT = 16;
  localparam int DEF_CNT_W = 16;
endpackage

// File: rtl/pipeline_stall_controller_if.sv
// pipeline_stall_controller_if: hazard/branch/SRAM inputs and stage control outputs
interface pipeline_stall_controller_if import arm_pipe_pkg::*; #(parameter int CNT_W = DEF_CNT_W);
  logic hazard_detected, forward_en, exe_mem_r_en, branch_taken, mem_req, sram_ready;
  logic sram_start, freeze_if, freeze_id, freeze_exe, freeze_mem, flush_id, bubble_exe, mem_error;
  logic [CNT_W-1:0] stall_cycles, flush_count;
  modport master(
    output hazard_detected, forward_en, exe_mem_r_en, branch_taken, mem_req, sram_ready,
    input sram_start, freeze_if, freeze_id, freeze_exe, freeze_mem, flush_id, bubble_exe, mem_error,
    input stall_cycles, flush_count
  );
  modport slave(
    input hazard_detected, forward_en, exe_mem_r_en, branch_taken, mem_req, sram_ready,
    output sram_start, freeze_if, freeze_id, freeze_exe, freeze_mem, flush_id, bubble_exe, mem_error,
    output stall_cycles, flush_count
  );
endinterface

// File: rtl/sat_counter.sv
// sat_counter: event counter that sticks at its maximum instead of wrapping
module sat_counter #(parameter int W = 16) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);
  always_ff @(posedge clk or posedge rst)
    if (rst) count <= '0;
    else if (inc && count != '1) count <= count + 1'b1;
endmodule

// File: rtl/pipeline_stall_controller.sv
// pipeline_stall_controller: stall/flush sequencer combining ID hazards, EXE branches and MEM SRAM waits
module pipeline_stall_controller import arm_pipe_pkg::*; #(
  parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
  parameter int CNT_W = DEF_CNT_W
) (
  input logic clk,
  input logic rst,
  pipeline_stall_controller_if.slave bus
);
  localparam int WC_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(MEM_TIMEOUT - 1);
  state_t state, next;
  logic [WC_W-1:0] wait_cnt;
  logic mem_error, mem_freeze, eff_hazard, go, start;
  always_comb begin
    start = !rst && state == ST_RUN && bus.mem_req;
    mem_freeze = start || (!rst && ((state == ST_MEM_WAIT && !bus.sram_ready) || state == ST_ERROR));
    eff_hazard = bus.hazard_detected && (!bus.forward_en || bus.exe_mem_r_en);
    go = !rst && !mem_freeze;
    next = start ? ST_MEM_WAIT :
           state != ST_MEM_WAIT ? state :
           bus.sram_ready ? ST_RUN :
           wait_cnt == WC_LAST ? ST_ERROR : ST_MEM_WAIT;
  end
  // a taken branch squashes the wrong-path hazard, so the hazard only acts without one
  assign bus.sram_start = start;
  assign bus.freeze_if  = mem_freeze || (go && !bus.branch_taken && eff_hazard);
  assign bus.freeze_id  = mem_freeze || (go && !bus.branch_taken && eff_hazard);
  assign bus.freeze_exe = mem_freeze;
  assign bus.freeze_mem = mem_freeze;
  assign bus.flush_id   = go && bus.branch_taken;
  assign bus.bubble_exe = go && (bus.branch_taken || eff_hazard);
  assign bus.mem_error  = mem_error;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= ST_RUN;
      wait_cnt <= '0;
      mem_error <= 1'b0;
    end else begin
      state <= next;
      wait_cnt <= state == ST_MEM_WAIT ? wait_cnt + 1'b1 : '0;
      mem_error <= mem_error || next == ST_ERROR;
    end
  sat_counter #(.W(CNT_W)) u_stall (.clk(clk), .rst(rst), .inc(bus.freeze_if), .count(bus.stall_cycles));
  sat_counter #(.W(CNT_W)) u_flush (.clk(clk), .rst(rst), .inc(bus.flush_id), .count(bus.flush_count));
endmodule

// File: tb/tb_pipeline_stall_controller.sv
// tb_pipeline_stall_controller: directed plus randomized checks against a behavioural model
module tb_pipeline_stall_controller;
  localparam int T = 4;
  localparam int W = 4;
  localparam int MAXC = (1 << W) - 1;
  logic clk = 1'b0;
  logic rst = 1'b0;
  pipeline_stall_controller_if #(.CNT_W(W)) bus();
  pipeline_stall_controller #(.MEM_TIMEOUT(T), .CNT_W(W)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int total = 0, bad = 0;
  bit waiting, err, merr;
  int waited, stalls, flushes;
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
    end
  endtask
  function automatic logic [6:0] ctl();
    return {bus.sram_start, bus.freeze_if, bus.freeze_id, bus.freeze_exe, bus.freeze_mem, bus.flush_id, bus.bubble_exe};
  endfunction
  task automatic drive(input bit hz, fw, rl, br, mr, rdy);
    bus.hazard_detected = hz;
    bus.forward_en = fw;
    bus.exe_mem_r_en = rl;
    bus.branch_taken = br;
    bus.mem_req = mr;
    bus.sram_ready = rdy;
  endtask
  task automatic step();
    bit idle_req, mf, eh, fif, flush;
    @(negedge clk);
    idle_req = !waiting && !err && bus.mem_req;
    mf = idle_req || (waiting && !bus.sram_ready) || err;
    eh = bus.hazard_detected && (!bus.forward_en || bus.exe_mem_r_en);
    fif = mf || (!bus.branch_taken && eh);
    flush = !mf && bus.branch_taken;
    check("ctl", ctl(), {idle_req, fif, fif, mf, mf, flush, !mf && (bus.branch_taken || eh)});
    check("stall_cycles", bus.stall_cycles, stalls);
    check("flush_count", bus.flush_count, flushes);
    check("mem_error", bus.mem_error, merr);
    if (fif && stalls < MAXC) stalls++;
    if (flush && flushes < MAXC) flushes++;
    if (waiting) begin
      if (bus.sram_ready) waiting = 0;
      else if (waited == T - 1) begin waiting = 0; err = 1; merr = 1; end
      else waited++;
    end else if (idle_req) begin
      waiting = 1;
      waited = 0;
    end
    @(posedge clk);
    #1;
  endtask
  task automatic cyc(input bit hz, fw, rl, br, mr, rdy);
    drive(hz, fw, rl, br, mr, rdy);
    step();
  endtask
  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_ctl", ctl(), 0);
    check("rst_cnt", {bus.stall_cycles, bus.flush_count}, 0);
    check("rst_err", bus.mem_error, 0);
    waiting = 0; err = 0; merr = 0; waited = 0; stalls = 0; flushes = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask
  initial begin
    drive(0, 0, 0, 0, 0, 0);
    #2;
    do_reset();
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    check("stall_two", bus.stall_cycles, 2);
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 1, 1, 0, 0, 0);
    check("stall_fwd_load", bus.stall_cycles, 3);
    cyc(1, 0, 0, 1, 0, 0);
    check("flush_one", bus.flush_count, 1);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 0, 0);
    check("stall_sram", bus.stall_cycles, 6);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 1, 0);
    cyc(1, 0, 0, 1, 1, 1);
    check("flush_after_wait", bus.flush_count, 2);
    cyc(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < T + 2; i++) cyc(0, 0, 0, i[0], 1, 0);
    cyc(0, 0, 0, 0, 0, 1);
    check("error_sticky", bus.mem_error, 1);
    do_reset();
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    do_reset();
    for (int i = 0; i < MAXC + 4; i++) cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < MAXC + 4; i++) cyc(1, 1, 0, 1, 0, 0);
    check("sat_both", {bus.stall_cycles, bus.flush_count}, {4'(MAXC), 4'(MAXC)});
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 49) == 0) do_reset();
      else cyc($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
               $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
